regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
//  Architectural register file with per-register rename tags; the receiving end of the ROB commit
//  interface. Issue stage renames rd to a ROB entry; ROB commit writes the retired value and
//  releases the tag if still current. Decoder reads rs1/rs2 combinationally and gets either a value
//  or the ROB position to wait on. Misprediction clear drops all tags; committed values are kept.
// PARAMETERS
//  ROB_POS_W   4   ROB index width (ROB_SIZE = 2**ROB_POS_W); wrapped pos width = ROB_POS_W+1
//  REG_NUM     32  architectural registers; index width 5
//  DATA_W      32  register data width
// PORTS
//  clk                    in   1          clock
//  rst                    in   1          synchronous active-high reset
//  rdy                    in   1          global ready; low = freeze all state
//  clr                    in   1          misprediction flush (from ROB, registered there)
//  issue_to_reg_enable    in   1          rename rd this cycle
//  issue_to_reg_rd        in   5          destination register being renamed
//  issue_to_reg_rob_pos   in   ROB_POS_W+1  wrapped ROB pos {1'b1,idx} of new owner
//  rob_to_reg_enable      in   1          commit write valid
//  rob_to_reg_rd          in   5          committed destination
//  rob_to_reg_val         in   DATA_W     committed value
//  commit_rob_pos         in   ROB_POS_W+1  wrapped pos of committing entry
//  dc_to_reg_rs1_pos      in   5          decoder source 1 index
//  dc_to_reg_rs2_pos      in   5          decoder source 2 index
//  reg_to_dc_rs1_val      out  DATA_W     rs1 value (valid when rs1_rob_pos==0)
//  reg_to_dc_rs1_rob_pos  out  ROB_POS_W+1  0 = ready; else ROB pos producing rs1
//  reg_to_dc_rs2_val      out  DATA_W     as rs1
//  reg_to_dc_rs2_rob_pos  out  ROB_POS_W+1  as rs1
// BEHAVIOUR
//  - State: val[REG_NUM], tag[REG_NUM] (ROB_POS_W+1 bits; 0 = not renamed, MSB set = renamed).
//  - Reset (rst, wins over everything incl. rdy=0): all val=0, all tag=0 -> outputs val=0, pos=0.
//  - rdy=0 and rst=0: no state change; read ports still combinational.
//  - x0: never written, never renamed; reads return val=0, pos=0 always.
//  - Commit (rob_to_reg_enable, rd!=0): val[rd]<=rob_to_reg_val next edge; tag[rd]<=0 only if
//    tag[rd]==commit_rob_pos (a younger rename must survive).
//  - Issue (issue_to_reg_enable, rd!=0, clr=0): tag[rd]<=issue_to_reg_rob_pos.
//  - Same cycle issue+commit on same rd: value written, issue tag wins over tag release.
//  - clr=1: all tags<=0; issue ignored; commit value write in the same cycle STILL applied
//    (JALR mispredict commits rd and raises clr together).
//  - Read (combinational, zero latency), per source rs:
//    rs==0 -> {0,0}; tag[rs]==0 -> {val[rs],0};
//    else if rob_to_reg_enable && rob_to_reg_rd==rs && commit_rob_pos==tag[rs]
//    -> {rob_to_reg_val,0} (commit bypass); else {val[rs],tag[rs]}.
//  - Reads ignore the same-cycle issue write: instruction reading and renaming the same
//    register (add x1,x1,x2) sees the previous owner.
//  - Tags compared on full wrapped width; no arithmetic; ROB index wrap handled by ROB.
// TESTING
//  1 rst 1 cycle -> rs1=5,rs2=31 read val 0, pos 0; commit x5=0xAA during rst -> ignored.
//  2 issue x3 pos 0x12; next cycle rs1=3 -> pos 0x12; commit x3 0x55 pos 0x12 same cycle ->
//    bypass val 0x55 pos 0; after edge rs1=3 -> val 0x55 pos 0.
//  3 issue x4 pos 0x11, then x4 pos 0x13; commit x4 0x7 pos 0x11 -> val[4]=7, tag stays 0x13.
//  4 same cycle issue x6 pos 0x14 + commit x6 0x9 pos 0x10 (tag 0x10) -> val 9, tag 0x14.
//  5 tags on x1,x2, then clr with commit x1 0xF0 pos=tag -> all pos 0, x1 reads 0xF0, issue dropped.
//  6 issue x0 pos 0x15 + commit x0 0x1 -> x0 reads 0/0; rdy=0 with issue x7 -> tag unchanged.

Source files
------------

// File: rtl/regfile_if.sv
// regfile_if: rename, commit, flush and decoder read signals of the architectural register file
interface regfile_if #(
    parameter int ROB_POS_W = 4,
    parameter int DATA_W    = 32
);
    logic                 rdy;
    logic                 clr;
    logic                 issue_to_reg_enable;
    logic [4:0]           issue_to_reg_rd;
    logic [ROB_POS_W:0]   issue_to_reg_rob_pos;
    logic                 rob_to_reg_enable;
    logic [4:0]           rob_to_reg_rd;
    logic [DATA_W-1:0]    rob_to_reg_val;
    logic [ROB_POS_W:0]   commit_rob_pos;
    logic [4:0]           dc_to_reg_rs1_pos;
    logic [4:0]           dc_to_reg_rs2_pos;
    logic [DATA_W-1:0]    reg_to_dc_rs1_val;
    logic [ROB_POS_W:0]   reg_to_dc_rs1_rob_pos;
    logic [DATA_W-1:0]    reg_to_dc_rs2_val;
    logic [ROB_POS_W:0]   reg_to_dc_rs2_rob_pos;

    modport master (
        output rdy, clr, issue_to_reg_enable, issue_to_reg_rd, issue_to_reg_rob_pos,
               rob_to_reg_enable, rob_to_reg_rd, rob_to_reg_val, commit_rob_pos,
               dc_to_reg_rs1_pos, dc_to_reg_rs2_pos,
        input  reg_to_dc_rs1_val, reg_to_dc_rs1_rob_pos, reg_to_dc_rs2_val, reg_to_dc_rs2_rob_pos
    );
    modport slave (
        input  rdy, clr, issue_to_reg_enable, issue_to_reg_rd, issue_to_reg_rob_pos,
               rob_to_reg_enable, rob_to_reg_rd, rob_to_reg_val, commit_rob_pos,
               dc_to_reg_rs1_pos, dc_to_reg_rs2_pos,
        output reg_to_dc_rs1_val, reg_to_dc_rs1_rob_pos, reg_to_dc_rs2_val, reg_to_dc_rs2_rob_pos
    );
endinterface

// File: rtl/regfile.sv
// regfile: architectural registers with rename tags, ROB commit write-back and combinational reads
module regfile #(
    parameter int ROB_POS_W = 4,
    parameter int REG_NUM   = 32,
    parameter int DATA_W    = 32
) (
    input logic       clk,
    input logic       rst,
    regfile_if.slave  bus
);
    localparam int PW = ROB_POS_W + 1;

    logic [DATA_W-1:0] val [REG_NUM];
    logic [PW-1:0]     tag [REG_NUM];
    logic [PW-1:0]     t1, t2;
    logic              h1, h2;

    // issue is applied after the tag release so a same-cycle rename survives the commit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val[i] <= '0;
                tag[i] <= '0;
            end
        end else if (bus.rdy) begin
            if (bus.clr)
                for (int i = 0; i < REG_NUM; i++) tag[i] <= '0;
            if (bus.rob_to_reg_enable && bus.rob_to_reg_rd != 5'd0) begin
                val[bus.rob_to_reg_rd] <= bus.rob_to_reg_val;
                if (!bus.clr && tag[bus.rob_to_reg_rd] == bus.commit_rob_pos)
                    tag[bus.rob_to_reg_rd] <= '0;
            end
            if (bus.issue_to_reg_enable && bus.issue_to_reg_rd != 5'd0 && !bus.clr)
                tag[bus.issue_to_reg_rd] <= bus.issue_to_reg_rob_pos;
        end
    end

    assign t1 = tag[bus.dc_to_reg_rs1_pos];
    assign t2 = tag[bus.dc_to_reg_rs2_pos];
    assign h1 = bus.rob_to_reg_enable && bus.rob_to_reg_rd == bus.dc_to_reg_rs1_pos
                && t1 != '0 && bus.commit_rob_pos == t1;
    assign h2 = bus.rob_to_reg_enable && bus.rob_to_reg_rd == bus.dc_to_reg_rs2_pos
                && t2 != '0 && bus.commit_rob_pos == t2;

    always_comb begin
        bus.reg_to_dc_rs1_val     = bus.dc_to_reg_rs1_pos == 5'd0 ? '0 : h1 ? bus.rob_to_reg_val : val[bus.dc_to_reg_rs1_pos];
        bus.reg_to_dc_rs1_rob_pos = (bus.dc_to_reg_rs1_pos == 5'd0 || h1) ? '0 : t1;
        bus.reg_to_dc_rs2_val     = bus.dc_to_reg_rs2_pos == 5'd0 ? '0 : h2 ? bus.rob_to_reg_val : val[bus.dc_to_reg_rs2_pos];
        bus.reg_to_dc_rs2_rob_pos = (bus.dc_to_reg_rs2_pos == 5'd0 || h2) ? '0 : t2;
    end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: table-driven vectors plus rename/commit sweeps, checked through an expectation queue
module tb_regfile;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_if #(.ROB_POS_W(4), .DATA_W(32)) bus ();
    regfile #(.ROB_POS_W(4), .REG_NUM(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic rst, rdy, clr, ie;
        logic [4:0] ird, ipos;
        logic ce;
        logic [4:0] crd;
        logic [31:0] cval;
        logic [4:0] cpos, rs1, rs2;
        logic [31:0] ev1;
        logic [4:0] ep1;
        logic [31:0] ev2;
        logic [4:0] ep2;
    } vec_t;

    typedef struct {
        logic [31:0] v1;
        logic [4:0]  p1;
        logic [31:0] v2;
        logic [4:0]  p2;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int step_no = 0;

    function automatic vec_t mk(logic r, logic rd_y, logic c, logic ie, logic [4:0] ird, logic [4:0] ipos,
                                logic ce, logic [4:0] crd, logic [31:0] cval, logic [4:0] cpos,
                                logic [4:0] rs1, logic [4:0] rs2, logic [31:0] ev1, logic [4:0] ep1,
                                logic [31:0] ev2, logic [4:0] ep2);
        vec_t v;
        v.rst = r; v.rdy = rd_y; v.clr = c; v.ie = ie; v.ird = ird; v.ipos = ipos;
        v.ce = ce; v.crd = crd; v.cval = cval; v.cpos = cpos; v.rs1 = rs1; v.rs2 = rs2;
        v.ev1 = ev1; v.ep1 = ep1; v.ev2 = ev2; v.ep2 = ep2;
        return v;
    endfunction

    function automatic logic [4:0] tg(int r);
        logic [3:0] lo = 4'(r);
        return r == 0 ? 5'd0 : {1'b1, lo};
    endfunction

    task automatic cmp(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", name, step_no, got, want);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue step %0d got empty want entry", step_no);
            return;
        end
        e = exp_q.pop_front();
        cmp("rs1_val", bus.reg_to_dc_rs1_val, e.v1);
        cmp("rs1_pos", 32'(bus.reg_to_dc_rs1_rob_pos), 32'(e.p1));
        cmp("rs2_val", bus.reg_to_dc_rs2_val, e.v2);
        cmp("rs2_pos", 32'(bus.reg_to_dc_rs2_rob_pos), 32'(e.p2));
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        rst = v.rst; bus.rdy = v.rdy; bus.clr = v.clr;
        bus.issue_to_reg_enable = v.ie; bus.issue_to_reg_rd = v.ird; bus.issue_to_reg_rob_pos = v.ipos;
        bus.rob_to_reg_enable = v.ce; bus.rob_to_reg_rd = v.crd; bus.rob_to_reg_val = v.cval;
        bus.commit_rob_pos = v.cpos; bus.dc_to_reg_rs1_pos = v.rs1; bus.dc_to_reg_rs2_pos = v.rs2;
        e.v1 = v.ev1; e.p1 = v.ep1; e.v2 = v.ev2; e.p2 = v.ep2;
        exp_q.push_back(e);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
        step_no++;
    endtask

    initial begin
        //            rst rdy clr ie ird  ipos   ce crd  cval   cpos   rs1 rs2  ev1  ep1    ev2 ep2
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,     1, 5, 32'hAA, 5'h10, 5, 31, 0, 0,     0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,     0, 0, 0, 0,        5, 31, 0, 0,     0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 3, 5'h12, 0, 0, 0, 0,        3, 5,  0, 0,     0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,     0, 0, 0, 0,        3, 1,  0, 5'h12, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,     1, 3, 32'h55, 5'h12, 3, 3, 32'h55, 0, 32'h55, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,     0, 0, 0, 0,        3, 0,  32'h55, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 4, 5'h11, 0, 0, 0, 0,        4, 3,  0, 0,     32'h55, 0));
        tbl.push_back(mk(0, 1, 0, 1, 4, 5'h13, 0, 0, 0, 0,        4, 0,  0, 5'h11, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,     1, 4, 7, 5'h11,    4, 3,  0, 5'h13, 32'h55, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,     0, 0, 0, 0,        4, 4,  7, 5'h13, 7, 5'h13));
        tbl.push_back(mk(0, 1, 0, 1, 6, 5'h10, 0, 0, 0, 0,        6, 4,  0, 0,     7, 5'h13));
        tbl.push_back(mk(0, 1, 0, 1, 6, 5'h14, 1, 6, 9, 5'h10,    6, 4,  9, 0,     7, 5'h13));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,     0, 0, 0, 0,        6, 0,  9, 5'h14, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 5'h15, 0, 0, 0, 0,        1, 2,  0, 0,     0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 2, 5'h16, 0, 0, 0, 0,        1, 2,  0, 5'h15, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 7, 5'h17, 1, 1, 32'hF0, 5'h15, 1, 2, 32'hF0, 0, 0, 5'h16));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,     0, 0, 0, 0,        1, 2,  32'hF0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,     0, 0, 0, 0,        7, 6,  0, 0,     9, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 5'h15, 1, 0, 1, 5'h15,    0, 0,  0, 0,     0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,     0, 0, 0, 0,        0, 0,  0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7, 5'h17, 1, 5, 32'h33, 5'h10, 7, 5, 0, 0,     0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,     0, 0, 0, 0,        7, 5,  0, 0,     0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 8, 5'h18, 0, 0, 0, 0,        8, 6,  0, 0,     9, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,     0, 0, 0, 0,        8, 6,  0, 5'h18, 9, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,     0, 0, 0, 0,        8, 6,  0, 0,     0, 0));

        rst = 1'b1;
        bus.rdy = 1'b1; bus.clr = 1'b0;
        bus.issue_to_reg_enable = 1'b0; bus.issue_to_reg_rd = '0; bus.issue_to_reg_rob_pos = '0;
        bus.rob_to_reg_enable = 1'b0; bus.rob_to_reg_rd = '0; bus.rob_to_reg_val = '0;
        bus.commit_rob_pos = '0; bus.dc_to_reg_rs1_pos = '0; bus.dc_to_reg_rs2_pos = '0;
        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i]);

        // rename every register, with rs2 watching the previously renamed one
        for (int r = 1; r < 32; r++)
            apply(mk(0, 1, 0, 1, 5'(r), tg(r), 0, 0, 0, 0, 5'(r), 5'(r - 1), 0, 0, 0, tg(r - 1)));
        // commit each in order: rs1 sees the bypass, rs2 the already retired neighbour
        for (int r = 1; r < 32; r++)
            apply(mk(0, 1, 0, 0, 0, 0, 1, 5'(r), 32'(r) * 32'h01010101, tg(r), 5'(r), 5'(r - 1),
                     32'(r) * 32'h01010101, 0, 32'(r - 1) * 32'h01010101, 0));
        for (int r = 0; r < 32; r += 2)
            apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'(r), 5'(r + 1),
                     32'(r) * 32'h01010101, 0, 32'(r + 1) * 32'h01010101, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
